uart_rx_frame_ctrl: RTL and testbench

Receive-side frame controller that sits directly behind `uart_rx` and sequences its byte strobes into checksummed frames. It hunts for a sync byte, captures a length-prefixed payload into an internal buffer, and verifies a two's-complement checksum. Only after verification does it release the payload on a valid/ready byte stream toward the consumer. Malformed, stalled or overrunning frames are discarded and flagged with single-cycle error pulses.

---
 rtl/uart_rx_frame_ctrl_if.sv | 35 +++
 rtl/uart_rx_frame_ctrl.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 521 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_ctrl_if
// Brief    : Byte-strobe input and payload stream output bundle of the
//            UART receive frame controller.
// Revision : 1.0
// ============================================================================
interface uart_rx_frame_ctrl_if;
    logic [7:0] rx_d_i;
    logic       rx_done_i;
    logic [7:0] m_data_o;
    logic       m_valid_o;
    logic       m_last_o;
    logic       m_ready_i;
    logic       frame_ok_o;
    logic       err_chk_o;
    logic       err_len_o;
    logic       err_timeout_o;
    logic       ovr_o;

    // Controller side
    modport slave (
        input  rx_d_i, rx_done_i, m_ready_i,
        output m_data_o, m_valid_o, m_last_o,
               frame_ok_o, err_chk_o, err_len_o, err_timeout_o, ovr_o
    );

    // Environment side: byte source plus payload consumer
    modport master (
        output rx_d_i, rx_done_i, m_ready_i,
        input  m_data_o, m_valid_o, m_last_o,
               frame_ok_o, err_chk_o, err_len_o, err_timeout_o, ovr_o
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_ctrl
// Brief    : Hunts for SYNC, buffers a length-prefixed payload, verifies the
//            two's-complement checksum, then drains it on a valid/ready stream.
// Revision : 1.0
// ============================================================================
module uart_rx_frame_ctrl #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         TIMEOUT_BITS = 20,
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC         = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_rx_frame_ctrl_if.slave  bus
);
    localparam int c_timeout_cycles = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int c_cnt_w = (c_timeout_cycles > 1) ? $clog2(c_timeout_cycles) : 1;
    localparam int c_idx_w = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_timeout_cycles - 1);
    localparam logic [7:0]         c_max_len  = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           len_q, len_d;
    logic [7:0]           sum_q, sum_d;
    logic [c_idx_w-1:0]   wr_idx_q, wr_idx_d;
    logic [c_idx_w-1:0]   rd_idx_q, rd_idx_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic                 frame_ok_q, frame_ok_d;
    logic                 err_chk_q, err_chk_d;
    logic                 err_len_q, err_len_d;
    logic                 err_timeout_q, err_timeout_d;
    logic                 ovr_q, ovr_d;
    logic [7:0]           buf_q [MAX_LEN];
    logic                 buf_we;

    logic                 w_drain;
    logic                 w_last;
    logic                 w_handshake;
    logic [7:0]           w_sum_next;

    assign w_drain     = (state_q == ST_DRAIN);
    assign w_last      = (8'(rd_idx_q) == len_q - 8'd1);
    assign w_handshake = w_drain && bus.m_ready_i;
    assign w_sum_next  = sum_q + bus.rx_d_i;

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        sum_d         = sum_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        cnt_d         = '0;
        frame_ok_d    = 1'b0;
        err_chk_d     = 1'b0;
        err_len_d     = 1'b0;
        err_timeout_d = 1'b0;
        ovr_d         = 1'b0;
        buf_we        = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (bus.rx_done_i && bus.rx_d_i == SYNC) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (bus.rx_done_i) begin
                    if (bus.rx_d_i != 8'h00 && bus.rx_d_i <= c_max_len) begin
                        len_d    = bus.rx_d_i;
                        sum_d    = bus.rx_d_i;
                        wr_idx_d = '0;
                        state_d  = ST_PAYLOAD;
                    end else begin
                        err_len_d = 1'b1;
                        state_d   = ST_HUNT;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (bus.rx_done_i) begin
                    buf_we   = 1'b1;
                    sum_d    = w_sum_next;
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (8'(wr_idx_q) == len_q - 8'd1) state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (bus.rx_done_i) begin
                    if (w_sum_next == 8'h00) begin
                        frame_ok_d = 1'b1;
                        rd_idx_d   = '0;
                        state_d    = ST_DRAIN;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = ST_HUNT;
                    end
                end
            end
            ST_DRAIN: begin
                // The UART is not consulted here; any byte is lost.
                ovr_d = bus.rx_done_i;
                if (w_handshake) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                    if (w_last) state_d = ST_HUNT;
                end
            end
            default: state_d = ST_HUNT;
        endcase

        // Inter-byte gap watchdog; a strobe in the expiry cycle takes priority.
        if ((state_q == ST_LEN || state_q == ST_PAYLOAD || state_q == ST_CHK) &&
            !bus.rx_done_i) begin
            if (cnt_q == c_cnt_last) begin
                err_timeout_d = 1'b1;
                state_d       = ST_HUNT;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_HUNT;
            len_q         <= '0;
            sum_q         <= '0;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            cnt_q         <= '0;
            frame_ok_q    <= 1'b0;
            err_chk_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            ovr_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            sum_q         <= sum_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            cnt_q         <= cnt_d;
            frame_ok_q    <= frame_ok_d;
            err_chk_q     <= err_chk_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
            ovr_q         <= ovr_d;
        end
    end

    // Payload storage needs no reset: it is only visible while draining.
    always_ff @(posedge clk) begin
        if (buf_we) buf_q[wr_idx_q] <= bus.rx_d_i;
    end

    assign bus.m_valid_o     = w_drain;
    assign bus.m_last_o      = w_drain && w_last;
    assign bus.m_data_o      = w_drain ? buf_q[rd_idx_q] : 8'h00;
    assign bus.frame_ok_o    = frame_ok_q;
    assign bus.err_chk_o     = err_chk_q;
    assign bus.err_len_o     = err_len_q;
    assign bus.err_timeout_o = err_timeout_q;
    assign bus.ovr_o         = ovr_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frame_ctrl
// Brief    : Self-checking bench for uart_rx_frame_ctrl with a frame-parser
//            reference model.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_frame_ctrl;
    localparam int         CLKS_PER_BIT = 4;
    localparam int         TIMEOUT_BITS = 5;
    localparam int         MAX_LEN      = 16;
    localparam logic [7:0] SYNC         = 8'hA5;
    localparam int         LIMIT        = CLKS_PER_BIT * TIMEOUT_BITS;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_rx_frame_ctrl_if bus();

    uart_rx_frame_ctrl #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .TIMEOUT_BITS (TIMEOUT_BITS),
        .MAX_LEN      (MAX_LEN),
        .SYNC         (SYNC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int ready_mode = 0;
    int pat_k = 0;

    logic [8:0] obs_q[$];
    int         obs_cyc[$];
    int         obs_ok, obs_chk, obs_len, obs_to, obs_ovr;
    logic [8:0] exp_q[$];
    int         exp_ok, exp_chk, exp_len;
    logic [7:0] stream[$];

    // Consumer-side monitor: records accepted beats, counts pulses, and
    // verifies that a stalled beat is held unchanged.
    logic       prev_stall = 1'b0;
    logic [8:0] prev_beat  = '0;
    always @(negedge clk) begin
        cycle++;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (bus.m_valid_o !== 1'b1 || {bus.m_last_o, bus.m_data_o} !== prev_beat) begin
                    errors++;
                    $display("FAIL hold_stable: got valid=%b beat=%h, required valid=1 beat=%h",
                             bus.m_valid_o, {bus.m_last_o, bus.m_data_o}, prev_beat);
                end
            end
            if (bus.m_valid_o && bus.m_ready_i) begin
                obs_q.push_back({bus.m_last_o, bus.m_data_o});
                obs_cyc.push_back(cycle);
            end
            obs_ok  += int'(bus.frame_ok_o);
            obs_chk += int'(bus.err_chk_o);
            obs_len += int'(bus.err_len_o);
            obs_to  += int'(bus.err_timeout_o);
            obs_ovr += int'(bus.ovr_o);
            prev_stall = bus.m_valid_o && !bus.m_ready_i;
            prev_beat  = {bus.m_last_o, bus.m_data_o};
        end
    end

    // Ready generator: 0 always, 1 random, 2 pattern 1,0,0,1, 3 never
    initial begin
        bus.m_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.m_ready_i = 1'b1;
                1:       bus.m_ready_i = 1'($urandom_range(0, 1));
                2: begin
                    bus.m_ready_i = (pat_k % 4 == 0) || (pat_k % 4 == 3);
                    pat_k++;
                end
                default: bus.m_ready_i = 1'b0;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all start and end 1 time unit after a rising edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        bus.rx_d_i    = b;
        bus.rx_done_i = 1'b1;
        tick(1);
        bus.rx_done_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (bus.m_valid_o === 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL drain_bound: m_valid_o still %b after %0d cycles, required 0", bus.m_valid_o, n);
        end
    endtask

    task automatic send_stream();
        foreach (stream[i]) begin
            strobe(stream[i]);
            wait_drain();
            tick($urandom_range(0, 4));
        end
    endtask

    task automatic make_frame(input int len, input bit bad);
        int s = len;
        logic [7:0] c;
        stream.push_back(SYNC);
        stream.push_back(8'(len));
        for (int k = 0; k < len; k++) begin
            c = 8'($urandom_range(0, 255));
            stream.push_back(c);
            s += int'(c);
        end
        c = 8'((256 - (s % 256)) % 256);
        if (bad) c = c ^ 8'($urandom_range(1, 255));
        stream.push_back(c);
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_cyc.delete();
        obs_ok = 0; obs_chk = 0; obs_len = 0; obs_to = 0; obs_ovr = 0;
    endtask

    // Reference model: parse the whole byte list as frames.
    task automatic run_model();
        int i = 0;
        int l, s;
        exp_q.delete();
        exp_ok = 0; exp_chk = 0; exp_len = 0;
        while (i < stream.size()) begin
            if (stream[i] != SYNC) begin
                i++;
                continue;
            end
            i++;
            if (i >= stream.size()) break;
            l = int'(stream[i]);
            i++;
            if (l == 0 || l > MAX_LEN) begin
                exp_len++;
                continue;
            end
            if (i + l >= stream.size()) break;
            s = l;
            for (int k = 0; k < l; k++) s += int'(stream[i + k]);
            if ((s + int'(stream[i + l])) % 256 == 0) begin
                exp_ok++;
                for (int k = 0; k < l; k++) exp_q.push_back({(k == l - 1), stream[i + k]});
            end else begin
                exp_chk++;
            end
            i += l + 1;
        end
    endtask

    function automatic int first_diff();
        int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [8:0] obs_at(input int d);
        return (d >= 0 && d < obs_q.size()) ? obs_q[d] : 9'h1ff;
    endfunction

    function automatic logic [8:0] exp_at(input int d);
        return (d >= 0 && d < exp_q.size()) ? exp_q[d] : 9'h1ff;
    endfunction

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        bus.rx_d_i    = 8'h00;
        bus.rx_done_i = 1'b0;
        reset         = 1'b1;
        tick(3);
        checks++;
        if (bus.m_valid_o !== 1'b0 || bus.m_last_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid_last: got %b%b, required 00", bus.m_valid_o, bus.m_last_o);
        end
        checks++;
        if (bus.m_data_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h, required 00", bus.m_data_o);
        end
        checks++;
        if ({bus.frame_ok_o, bus.err_chk_o, bus.err_len_o, bus.err_timeout_o, bus.ovr_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses: got %b, required 00000",
                     {bus.frame_ok_o, bus.err_chk_o, bus.err_len_o, bus.err_timeout_o, bus.ovr_o});
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_good_frame();
        int d;
        ready_mode = 0;
        clear_obs();
        stream = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
        send_stream();
        strobe(8'h97);
        checks++;
        if ({bus.frame_ok_o, bus.m_valid_o, bus.m_data_o} !== {1'b1, 1'b1, 8'h11}) begin
            errors++;
            $display("FAIL good_first_cycle: got ok=%b valid=%b data=%h, required ok=1 valid=1 data=11",
                     bus.frame_ok_o, bus.m_valid_o, bus.m_data_o);
        end
        wait_drain();
        tick(2);
        stream.push_back(8'h97);
        run_model();
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL good_payload: beat %0d got %h required %h (%0d vs %0d beats)",
                     d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
        end
        checks++;
        if (obs_ok != exp_ok) begin
            errors++;
            $display("FAIL good_ok_count: got %0d required %0d", obs_ok, exp_ok);
        end
        checks++;
        if (obs_cyc.size() != 3 || obs_cyc[obs_cyc.size() - 1] - obs_cyc[0] != 2) begin
            errors++;
            $display("FAIL good_back_to_back: got %0d beats spread over %0d cycles, required 3 over 2",
                     obs_cyc.size(), (obs_cyc.size() > 0) ? obs_cyc[obs_cyc.size() - 1] - obs_cyc[0] : -1);
        end
    endtask

    task automatic test_garbage_chk();
        int d;
        ready_mode = 0;
        clear_obs();
        stream = '{8'hFF, 8'h00, 8'hA5, 8'h01, 8'h7E, 8'h81, 8'hA5, 8'h01, 8'h7E, 8'h80};
        send_stream();
        tick(3);
        run_model();
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL garbage_payload: beat %0d got %h required %h (%0d vs %0d beats)",
                     d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
        end
        checks++;
        if (obs_ok != exp_ok || obs_chk != exp_chk) begin
            errors++;
            $display("FAIL garbage_ok_chk: got ok=%0d chk=%0d required ok=%0d chk=%0d",
                     obs_ok, obs_chk, exp_ok, exp_chk);
        end
    endtask

    task automatic test_len_err();
        int d;
        ready_mode = 0;
        clear_obs();
        stream = '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h02, 8'h10, 8'h20, 8'hCE};
        send_stream();
        tick(3);
        run_model();
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL len_payload: beat %0d got %h required %h (%0d vs %0d beats)",
                     d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
        end
        checks++;
        if (obs_len != exp_len || obs_ok != exp_ok) begin
            errors++;
            $display("FAIL len_counts: got len=%0d ok=%0d required len=%0d ok=%0d",
                     obs_len, obs_ok, exp_len, exp_ok);
        end
    endtask

    task automatic test_timeout();
        int d;
        ready_mode = 0;
        clear_obs();
        strobe(8'hA5); strobe(8'h02); strobe(8'h44);
        tick(LIMIT - 1);
        checks++;
        if (bus.err_timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got %b, required 0", bus.err_timeout_o);
        end
        tick(1);
        checks++;
        if (bus.err_timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire: got %b, required 1", bus.err_timeout_o);
        end
        tick(30);
        checks++;
        if (obs_to != 1) begin
            errors++;
            $display("FAIL timeout_count: got %0d, required 1", obs_to);
        end
        // Boundary: byte arrives in the cycle the gap would expire
        clear_obs();
        strobe(8'hA5); strobe(8'h02); strobe(8'h44);
        tick(LIMIT - 1);
        strobe(8'h55);
        strobe(8'h65);
        wait_drain();
        tick(2);
        stream = '{8'hA5, 8'h02, 8'h44, 8'h55, 8'h65};
        run_model();
        d = first_diff();
        checks++;
        if (d != -1 || obs_to != 0) begin
            errors++;
            $display("FAIL timeout_boundary: beat %0d got %h required %h, timeouts got %0d required 0",
                     d, obs_at(d), exp_at(d), obs_to);
        end
    endtask

    task automatic test_backpressure();
        int d;
        ready_mode = 2;
        pat_k      = 0;
        clear_obs();
        stream.delete();
        make_frame(4, 1'b0);
        send_stream();
        tick(3);
        run_model();
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL backpressure_payload: beat %0d got %h required %h (%0d vs %0d beats)",
                     d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_overrun();
        int d;
        ready_mode = 3;
        clear_obs();
        stream.delete();
        make_frame(4, 1'b0);
        foreach (stream[i]) strobe(stream[i]);
        tick(2);
        strobe(SYNC);
        checks++;
        if (bus.ovr_o !== 1'b1 || bus.m_data_o !== stream[2]) begin
            errors++;
            $display("FAIL overrun_pulse: got ovr=%b data=%h, required ovr=1 data=%h",
                     bus.ovr_o, bus.m_data_o, stream[2]);
        end
        ready_mode = 0;
        tick(1);
        wait_drain();
        tick(2);
        run_model();
        d = first_diff();
        checks++;
        if (d != -1 || obs_ovr != 1) begin
            errors++;
            $display("FAIL overrun_payload: beat %0d got %h required %h, ovr got %0d required 1",
                     d, obs_at(d), exp_at(d), obs_ovr);
        end
    endtask

    task automatic test_reset_mid();
        int d;
        ready_mode = 0;
        clear_obs();
        strobe(8'hA5); strobe(8'h05); strobe(8'h01); strobe(8'h02);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if ({bus.m_valid_o, bus.frame_ok_o, bus.err_chk_o, bus.err_len_o, bus.err_timeout_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_payload_outputs: got %b, required 00000",
                     {bus.m_valid_o, bus.frame_ok_o, bus.err_chk_o, bus.err_len_o, bus.err_timeout_o});
        end
        // Mid-drain
        ready_mode = 3;
        stream.delete();
        make_frame(3, 1'b0);
        foreach (stream[i]) strobe(stream[i]);
        tick(2);
        checks++;
        if (bus.m_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_drain_pre: got valid=%b, required 1", bus.m_valid_o);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if ({bus.m_valid_o, bus.m_last_o, bus.m_data_o} !== 10'b0) begin
            errors++;
            $display("FAIL reset_drain_outputs: got valid=%b last=%b data=%h, required 0 0 00",
                     bus.m_valid_o, bus.m_last_o, bus.m_data_o);
        end
        checks++;
        if (obs_chk + obs_len + obs_to + obs_ovr != 0) begin
            errors++;
            $display("FAIL reset_no_errors: got %0d error pulses, required 0",
                     obs_chk + obs_len + obs_to + obs_ovr);
        end
        ready_mode = 0;
        clear_obs();
        stream.delete();
        make_frame(5, 1'b0);
        send_stream();
        tick(3);
        run_model();
        d = first_diff();
        checks++;
        if (d != -1 || obs_ok != 1) begin
            errors++;
            $display("FAIL reset_recover: beat %0d got %h required %h, ok got %0d required 1",
                     d, obs_at(d), exp_at(d), obs_ok);
        end
    endtask

    task automatic test_random();
        int d, kind;
        logic [7:0] g;
        ready_mode = 1;
        clear_obs();
        stream.delete();
        for (int f = 0; f < 30; f++) begin
            repeat ($urandom_range(0, 3)) begin
                g = 8'($urandom_range(0, 255));
                if (g == SYNC) g = 8'h5A;
                stream.push_back(g);
            end
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                stream.push_back(SYNC);
                stream.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
            end else begin
                make_frame((kind == 2) ? MAX_LEN : $urandom_range(1, MAX_LEN), kind == 1);
            end
        end
        send_stream();
        tick(5);
        run_model();
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL random_payload: beat %0d got %h required %h (%0d vs %0d beats)",
                     d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
        end
        checks++;
        if (obs_ok != exp_ok || obs_chk != exp_chk || obs_len != exp_len) begin
            errors++;
            $display("FAIL random_counts: got ok=%0d chk=%0d len=%0d required ok=%0d chk=%0d len=%0d",
                     obs_ok, obs_chk, obs_len, exp_ok, exp_chk, exp_len);
        end
        checks++;
        if (obs_to != 0 || obs_ovr != 0) begin
            errors++;
            $display("FAIL random_spurious: got timeouts=%0d overruns=%0d, required 0 0", obs_to, obs_ovr);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_garbage_chk();
        test_len_err();
        test_timeout();
        test_backpressure();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
